// File: rtl/mem_line_responder_if.sv
// Line-fill/writeback bus between the cache controller (master) and its backing store (slave).
// Request, write-beat and read-beat channels are each valid/ready handshaked.
interface mem_line_responder_if #(
    parameter int LADDR_W = 8,
    parameter int DATA_W  = 32
);
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [LADDR_W-1:0] req_addr;
    logic               wdata_valid;
    logic               wdata_ready;
    logic [DATA_W-1:0]  wdata;
    logic               rdata_valid;
    logic               rdata_ready;
    logic [DATA_W-1:0]  rdata;
    logic               rdata_last;
    logic               wr_done;
    logic               busy;

    modport master (
        output req_valid, req_write, req_addr, wdata_valid, wdata, rdata_ready,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, wdata_valid, wdata, rdata_ready,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy
    );
endinterface

// File: rtl/mem_line_responder.sv
// Whole-line backing store; fills return LATENCY cycles after the request, writebacks ack LATENCY after the last beat.
// One request outstanding: req_ready only in IDLE, write beats stall on wdata_valid, read beats hold on rdata_ready.
module mem_line_responder #(
    parameter int LADDR_W = 8,
    parameter int DATA_W  = 32,
    parameter int WORDS   = 4,
    parameter int LATENCY = 4
) (
    input logic                 clk,
    input logic                 rst,
    mem_line_responder_if.slave bus
);
    localparam int BEAT_W = $clog2(WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH  = (2 ** LADDR_W) * WORDS;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WBURST, WAIT, RBURST, WDONE} state_t;

    state_t               state_q, state_d;
    logic [LADDR_W-1:0]   addr_q, addr_d;
    logic                 write_q, write_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem [DEPTH];

    // Beat counter sits in the low index bits so it can never carry into the line address.
    logic [LADDR_W+BEAT_W-1:0] mem_idx;
    assign mem_idx = {addr_q, beat_q};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        write_d         = write_q;
        beat_d          = beat_q;
        cnt_d           = cnt_q;
        mem_we          = 1'b0;
        bus.req_ready   = 1'b0;
        bus.wdata_ready = 1'b0;
        bus.rdata_valid = 1'b0;
        bus.rdata       = '0;
        bus.rdata_last  = 1'b0;
        bus.wr_done     = 1'b0;
        bus.busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    write_d = bus.req_write;
                    beat_d  = '0;
                    if (bus.req_write) begin
                        state_d = WBURST;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WBURST: begin
                bus.wdata_ready = 1'b1;
                if (bus.wdata_valid) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        cnt_d   = LAT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = write_q ? WDONE : RBURST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RBURST: begin
                bus.rdata_valid = 1'b1;
                bus.rdata       = mem[mem_idx];
                bus.rdata_last  = (beat_q == LAST_BEAT);
                if (bus.rdata_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            WDONE: begin
                bus.wr_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage survives reset; a writeback cut short by reset leaves its earlier beats in place.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized fill/writeback traffic against a line-level reference store, plus directed corner cases.
// Main instance runs LATENCY=4; two side instances share stimulus to measure LATENCY=1 and 7.
module tb_mem_line_responder;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0][31:0] ref_line [int];

    mem_line_responder_if #(.LADDR_W(8), .DATA_W(32)) bus ();
    mem_line_responder_if #(.LADDR_W(8), .DATA_W(32)) b1 ();
    mem_line_responder_if #(.LADDR_W(8), .DATA_W(32)) b7 ();

    mem_line_responder #(.LADDR_W(8), .DATA_W(32), .WORDS(4), .LATENCY(L))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));
    mem_line_responder #(.LADDR_W(8), .DATA_W(32), .WORDS(4), .LATENCY(1))
        dut_l1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_line_responder #(.LADDR_W(8), .DATA_W(32), .WORDS(4), .LATENCY(7))
        dut_l7 (.clk(clk), .rst(rst), .bus(b7.slave));

    logic        sw_req_valid, sw_req_write, sw_wdata_valid;
    logic [7:0]  sw_req_addr;
    logic [31:0] sw_wdata;
    assign b1.req_valid   = sw_req_valid;   assign b7.req_valid   = sw_req_valid;
    assign b1.req_write   = sw_req_write;   assign b7.req_write   = sw_req_write;
    assign b1.req_addr    = sw_req_addr;    assign b7.req_addr    = sw_req_addr;
    assign b1.wdata_valid = sw_wdata_valid; assign b7.wdata_valid = sw_wdata_valid;
    assign b1.wdata       = sw_wdata;       assign b7.wdata       = sw_wdata;
    assign b1.rdata_ready = 1'b1;           assign b7.rdata_ready = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called and returns at a falling edge. hold=1 leaves a read of the same line requested.
    task automatic do_write(input logic [7:0] a, input logic [3:0][31:0] d,
                            input logic [3:0][3:0] gaps, input bit hold);
        int k;
        int m;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a;
        k = 0;
        while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
        chk("wr_req_accept", 32'(k < 50), 1);
        @(negedge clk);
        if (hold) bus.req_write = 1'b0; else bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'(gaps[i]); g++) begin
                chk("wr_stall_busy", bus.busy, 1);
                @(negedge clk);
            end
            chk("wr_wdata_ready", bus.wdata_ready, 1);
            chk("wr_blocked", bus.req_ready, 0);
            bus.wdata_valid = 1'b1; bus.wdata = d[i];
            @(negedge clk);
            bus.wdata_valid = 1'b0; bus.wdata = $urandom;
        end
        m = cyc;
        k = 0;
        while (!bus.wr_done && k < 20) begin
            chk("wr_wait_blocked", bus.req_ready, 0);
            @(negedge clk); k++;
        end
        chk("wr_done_latency", cyc - m, L);
        chk("wr_done_blocked", bus.req_ready, 0);
        ref_line[a] = d;
        @(negedge clk);
        chk("wr_done_pulse", bus.wr_done, 0);
        chk("wr_idle_ready", bus.req_ready, 1);
    endtask

    // pat bit j (cyclic) drives rdata_ready on the j-th beat cycle; rst_after >= 0 resets after that many beats.
    task automatic do_read(input logic [7:0] a, input logic [15:0] pat, input int rst_after);
        int k;
        int n;
        int i;
        int j;
        logic [3:0][31:0] exp;
        exp = ref_line[a];
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a;
        k = 0;
        while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
        chk("rd_req_accept", 32'(k < 50), 1);
        @(negedge clk);
        n = cyc;
        bus.req_valid = 1'b0;
        k = 0;
        while (!bus.rdata_valid && k < 20) begin
            chk("rd_wait_blocked", bus.req_ready, 0);
            bus.wdata_valid = 1'($urandom); bus.wdata = $urandom;
            @(negedge clk); k++;
        end
        chk("rd_latency", cyc - n, L);
        i = 0;
        j = 0;
        while (i < 4 && j < 64) begin
            if (i == rst_after) begin
                rst = 1'b1;
                #1;
                chk("rst_req_ready", bus.req_ready, 1);
                chk("rst_wdata_ready", bus.wdata_ready, 0);
                chk("rst_rdata_valid", bus.rdata_valid, 0);
                chk("rst_rdata_last", bus.rdata_last, 0);
                chk("rst_rdata", bus.rdata, 0);
                chk("rst_wr_done", bus.wr_done, 0);
                chk("rst_busy", bus.busy, 0);
                @(negedge clk);
                rst = 1'b0; bus.rdata_ready = 1'b0; bus.wdata_valid = 1'b0;
                return;
            end
            chk("rd_valid", bus.rdata_valid, 1);
            chk("rd_data", bus.rdata, exp[i]);
            chk("rd_last", bus.rdata_last, 32'(i == 3));
            bus.rdata_ready = pat[j % 16];
            bus.wdata_valid = 1'($urandom); bus.wdata = $urandom;
            @(negedge clk);
            if (bus.rdata_ready) i++;
            j++;
        end
        bus.rdata_ready = 1'b0; bus.wdata_valid = 1'b0;
        chk("rd_beat_count", i, 4);
        chk("rd_end_valid", bus.rdata_valid, 0);
        chk("rd_end_ready", bus.req_ready, 1);
        chk("rd_end_busy", bus.busy, 0);
    endtask

    initial begin
        logic [3:0][31:0] d;
        logic [3:0][3:0]  gaps;
        logic [7:0]       a;
        int m;
        int t1;
        int t7;
        logic [31:0] d1;
        logic [31:0] d7;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.wdata_valid = 1'b0; bus.wdata = '0; bus.rdata_ready = 1'b0;
        sw_req_valid = 1'b0; sw_req_write = 1'b0; sw_req_addr = '0;
        sw_wdata_valid = 1'b0; sw_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_wdata_ready", bus.wdata_ready, 0);
        chk("reset_rdata_valid", bus.rdata_valid, 0);
        chk("reset_rdata_last", bus.rdata_last, 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_wr_done", bus.wr_done, 0);
        chk("reset_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        do_write(8'h2A, {32'd4, 32'd3, 32'd2, 32'd1}, '0, 1'b0);
        do_read(8'h2A, 16'hFFFF, -1);
        do_read(8'h2A, 16'hFF59, -1);

        bus.wdata_valid = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        repeat (3) begin
            chk("idle_wdata_ready", bus.wdata_ready, 0);
            @(negedge clk);
        end
        bus.wdata_valid = 1'b0;
        do_read(8'h2A, 16'hFFFF, -1);

        do_write(8'h00, {32'h0000_0B03, 32'h0000_0B02, 32'h0000_0B01, 32'h0000_0B00}, '0, 1'b0);
        gaps = '0;
        gaps[2] = 4'd3;
        do_write(8'hFF, {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0}, gaps, 1'b0);
        do_read(8'hFF, 16'hFFFF, -1);
        do_read(8'h00, 16'hFFFF, -1);

        for (int w = 0; w < 4; w++) d[w] = $urandom;
        do_write(8'h11, d, '0, 1'b1);
        do_read(8'h11, 16'hFFFF, -1);

        do_read(8'h2A, 16'hFFFF, 1);
        do_read(8'h2A, 16'hFFFF, -1);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                2:       a = 8'h2A;
                default: a = 8'($urandom);
            endcase
            if ($urandom_range(0, 1) == 0 || !ref_line.exists(int'(a))) begin
                for (int w = 0; w < 4; w++) begin
                    d[w]    = $urandom;
                    gaps[w] = 4'($urandom_range(0, 2));
                end
                do_write(a, d, gaps, 1'b0);
            end else begin
                do_read(a, 16'($urandom) | 16'h0001, -1);
            end
        end

        chk("sweep_idle", {30'd0, b1.req_ready, b7.req_ready}, 3);
        sw_req_valid = 1'b1; sw_req_write = 1'b1; sw_req_addr = 8'h5A;
        @(negedge clk);
        sw_req_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            sw_wdata_valid = 1'b1; sw_wdata = 32'hC0DE_0000 + 32'(w);
            @(negedge clk);
        end
        sw_wdata_valid = 1'b0;
        m = cyc; t1 = -1; t7 = -1;
        for (int k = 0; k < 20; k++) begin
            if (b1.wr_done && t1 < 0) t1 = cyc - m;
            if (b7.wr_done && t7 < 0) t7 = cyc - m;
            @(negedge clk);
        end
        chk("sweep_wr_lat1", t1, 1);
        chk("sweep_wr_lat7", t7, 7);
        chk("sweep_idle2", {30'd0, b1.req_ready, b7.req_ready}, 3);
        sw_req_valid = 1'b1; sw_req_write = 1'b0;
        @(negedge clk);
        sw_req_valid = 1'b0;
        m = cyc; t1 = -1; t7 = -1; d1 = '0; d7 = '0;
        for (int k = 0; k < 20; k++) begin
            if (b1.rdata_valid && t1 < 0) begin t1 = cyc - m; d1 = b1.rdata; end
            if (b7.rdata_valid && t7 < 0) begin t7 = cyc - m; d7 = b7.rdata; end
            @(negedge clk);
        end
        chk("sweep_rd_lat1", t1, 1);
        chk("sweep_rd_lat7", t7, 7);
        chk("sweep_rd_data1", d1, 32'hC0DE_0000);
        chk("sweep_rd_data7", d7, 32'hC0DE_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
